// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared widths, FSM encoding and metadata type for branch resolution
package branch_resolve_unit_pkg;

  localparam int PHT_INDEX_BITS_DFLT = 8;
  localparam int BTB_INDEX_BITS_DFLT = 6;
  localparam int BTB_TAG_BITS_DFLT   = 20;
  localparam int CNT_W_DFLT          = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } bru_state_e;

  // Prediction made at fetch, travelling alongside the IF/ID register
  typedef struct packed {
    logic        valid;
    logic        pred_taken;
    logic        btb_hit;
    logic [31:0] btb_target;
  } bru_meta_t;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - fetch/decode-side bus of the branch resolve unit
interface branch_resolve_unit_if
  import branch_resolve_unit_pkg::*;
#(
  parameter int PHT_INDEX_BITS = PHT_INDEX_BITS_DFLT,
  parameter int BTB_INDEX_BITS = BTB_INDEX_BITS_DFLT,
  parameter int BTB_TAG_BITS   = BTB_TAG_BITS_DFLT,
  parameter int CNT_W          = CNT_W_DFLT
);

  logic                      if_fire;
  logic                      if_pred_taken;
  logic                      if_btb_hit;
  logic [31:0]               if_btb_target;
  logic                      id_fire;
  logic [31:0]               id_pc;
  logic                      id_is_branch;
  logic                      id_is_jump;
  logic                      id_taken;
  logic [31:0]               id_target;
  logic                      pred_update_en;
  logic [PHT_INDEX_BITS-1:0] pred_update_index;
  logic                      pred_update_taken;
  logic                      btb_update_en;
  logic [BTB_INDEX_BITS-1:0] btb_update_index;
  logic [BTB_TAG_BITS-1:0]   btb_update_tag;
  logic [31:0]               btb_update_target;
  logic                      redirect_valid;
  logic [31:0]               redirect_pc;
  logic                      flush_if_id;
  logic [CNT_W-1:0]          cnt_branches;
  logic [CNT_W-1:0]          cnt_mispredicts;

  modport master (
    output if_fire, if_pred_taken, if_btb_hit, if_btb_target,
    output id_fire, id_pc, id_is_branch, id_is_jump, id_taken, id_target,
    input  pred_update_en, pred_update_index, pred_update_taken,
    input  btb_update_en, btb_update_index, btb_update_tag, btb_update_target,
    input  redirect_valid, redirect_pc, flush_if_id,
    input  cnt_branches, cnt_mispredicts
  );

  modport slave (
    input  if_fire, if_pred_taken, if_btb_hit, if_btb_target,
    input  id_fire, id_pc, id_is_branch, id_is_jump, id_taken, id_target,
    output pred_update_en, pred_update_index, pred_update_taken,
    output btb_update_en, btb_update_index, btb_update_tag, btb_update_target,
    output redirect_valid, redirect_pc, flush_if_id,
    output cnt_branches, cnt_mispredicts
  );

endinterface

// File: rtl/branch_resolve_unit_sat_counter.sv
// rtl/branch_resolve_unit_sat_counter.sv - saturating up-counter
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - ID-stage branch resolution, predictor/BTB update and mispredict redirect
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int PHT_INDEX_BITS = PHT_INDEX_BITS_DFLT,
  parameter int BTB_INDEX_BITS = BTB_INDEX_BITS_DFLT,
  parameter int BTB_TAG_BITS   = BTB_TAG_BITS_DFLT,
  parameter int CNT_W          = CNT_W_DFLT
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_resolve_unit_if.slave bus
);

  bru_meta_t  meta;
  bru_state_e state;

  logic [31:0] pc_seq;
  logic [31:0] pnext;
  logic [31:0] anext;
  logic        act_taken;
  logic        res;
  logic        mis;
  logic        btb_wr;

  logic                      redirect_valid_q;
  logic [31:0]               redirect_pc_q;
  logic                      flush_q;
  logic                      pred_en_q;
  logic [PHT_INDEX_BITS-1:0] pred_index_q;
  logic                      pred_taken_q;
  logic                      btb_en_q;
  logic [BTB_INDEX_BITS-1:0] btb_index_q;
  logic [BTB_TAG_BITS-1:0]   btb_tag_q;
  logic [31:0]               btb_target_q;
  logic [CNT_W-1:0]          cnt_br;
  logic [CNT_W-1:0]          cnt_mis;

  assign pc_seq    = seq_pc(bus.id_pc);
  assign pnext     = (meta.pred_taken && meta.btb_hit) ? meta.btb_target : pc_seq;
  assign act_taken = bus.id_is_jump | (bus.id_is_branch & bus.id_taken);
  assign anext     = act_taken ? bus.id_target : pc_seq;
  assign res       = bus.id_fire & meta.valid & (state == IDLE);
  // Comparing full next-PCs also catches stale BTB aliases on non-control instructions
  assign mis       = res & (pnext != anext);
  assign btb_wr    = res & act_taken & (~meta.btb_hit | (meta.btb_target != bus.id_target));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
    end else if (flush_q) begin
      meta.valid <= 1'b0;
    end else if (bus.if_fire) begin
      meta <= '{valid: 1'b1, pred_taken: bus.if_pred_taken,
                btb_hit: bus.if_btb_hit, btb_target: bus.if_btb_target};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          redirect_valid_q <= mis;
          flush_q          <= mis;
          if (mis) begin
            state         <= RECOVER;
            redirect_pc_q <= anext;
          end
        end
        RECOVER: begin
          state            <= IDLE;
          redirect_valid_q <= 1'b0;
          flush_q          <= 1'b0;
        end
        default: begin
          state            <= IDLE;
          redirect_valid_q <= 1'b0;
          flush_q          <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_en_q    <= 1'b0;
      pred_index_q <= '0;
      pred_taken_q <= 1'b0;
      btb_en_q     <= 1'b0;
      btb_index_q  <= '0;
      btb_tag_q    <= '0;
      btb_target_q <= '0;
    end else begin
      pred_en_q <= res & bus.id_is_branch;
      btb_en_q  <= btb_wr;
      if (res) begin
        pred_index_q <= bus.id_pc[PHT_INDEX_BITS+1:2];
        pred_taken_q <= bus.id_taken;
        btb_index_q  <= bus.id_pc[BTB_INDEX_BITS+5:6];
        btb_tag_q    <= bus.id_pc[31:32-BTB_TAG_BITS];
        btb_target_q <= bus.id_target;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_branches (
    .clk   (clk),
    .rst_n (reset),
    .inc   (res & (bus.id_is_branch | bus.id_is_jump)),
    .count (cnt_br)
  );

  sat_counter #(.W(CNT_W)) u_cnt_mispredicts (
    .clk   (clk),
    .rst_n (reset),
    .inc   (mis),
    .count (cnt_mis)
  );

  assign bus.pred_update_en    = pred_en_q;
  assign bus.pred_update_index = pred_index_q;
  assign bus.pred_update_taken = pred_taken_q;
  assign bus.btb_update_en     = btb_en_q;
  assign bus.btb_update_index  = btb_index_q;
  assign bus.btb_update_tag    = btb_tag_q;
  assign bus.btb_update_target = btb_target_q;
  assign bus.redirect_valid    = redirect_valid_q;
  assign bus.redirect_pc       = redirect_pc_q;
  assign bus.flush_if_id       = flush_q;
  assign bus.cnt_branches      = cnt_br;
  assign bus.cnt_mispredicts   = cnt_mis;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if bus ();
  branch_resolve_unit_if #(.CNT_W(3)) bus_s ();

  branch_resolve_unit dut (.clk(clk), .reset(reset), .bus(bus));
  branch_resolve_unit #(.CNT_W(3)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.if_fire = 0; bus.if_pred_taken = 0; bus.if_btb_hit = 0; bus.if_btb_target = 0;
    bus.id_fire = 0; bus.id_pc = 0; bus.id_is_branch = 0; bus.id_is_jump = 0;
    bus.id_taken = 0; bus.id_target = 0;
    bus_s.if_fire = 0; bus_s.if_pred_taken = 0; bus_s.if_btb_hit = 0; bus_s.if_btb_target = 0;
    bus_s.id_fire = 0; bus_s.id_pc = 0; bus_s.id_is_branch = 0; bus_s.id_is_jump = 0;
    bus_s.id_taken = 0; bus_s.id_target = 0;
  endtask

  task automatic load_meta(input logic pt, input logic hit, input logic [31:0] tgt);
    bus.if_fire = 1; bus.if_pred_taken = pt; bus.if_btb_hit = hit; bus.if_btb_target = tgt;
    step();
    bus.if_fire = 0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic br, input logic jmp,
                         input logic tk, input logic [31:0] tgt);
    bus.id_pc = pc; bus.id_is_branch = br; bus.id_is_jump = jmp;
    bus.id_taken = tk; bus.id_target = tgt; bus.id_fire = 1;
    step();
    bus.id_fire = 0;
  endtask

  task automatic test_reset;
    checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL rst_redirect got=%0h exp=0", bus.redirect_valid); end
    checks++; if (bus.flush_if_id !== 1'b0) begin failures++; $display("FAIL rst_flush got=%0h exp=0", bus.flush_if_id); end
    checks++; if (bus.pred_update_en !== 1'b0 || bus.btb_update_en !== 1'b0) begin failures++; $display("FAIL rst_update_en got=%0h/%0h exp=0/0", bus.pred_update_en, bus.btb_update_en); end
    checks++; if (bus.cnt_branches !== 32'd0 || bus.cnt_mispredicts !== 32'd0) begin failures++; $display("FAIL rst_counters got=%0h/%0h exp=0/0", bus.cnt_branches, bus.cnt_mispredicts); end
    reset = 1;
    step();
    checks++; if (bus.redirect_pc !== 32'd0 || bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL rst_after_release got=%0h/%0h exp=0/0", bus.redirect_valid, bus.redirect_pc); end
  endtask

  task automatic test_mispredict_branch;
    load_meta(0, 0, 32'h0);
    resolve(32'h40, 1, 0, 1, 32'h80);
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h80) begin failures++; $display("FAIL t1_redirect got=%0h/%0h exp=1/80", bus.redirect_valid, bus.redirect_pc); end
    checks++; if (bus.flush_if_id !== 1'b1) begin failures++; $display("FAIL t1_flush got=%0h exp=1", bus.flush_if_id); end
    checks++; if (bus.pred_update_en !== 1'b1 || bus.pred_update_index !== 8'h10 || bus.pred_update_taken !== 1'b1) begin failures++; $display("FAIL t1_pred got=%0h/%0h/%0h exp=1/10/1", bus.pred_update_en, bus.pred_update_index, bus.pred_update_taken); end
    checks++; if (bus.btb_update_en !== 1'b1 || bus.btb_update_index !== 6'h01 || bus.btb_update_tag !== 20'h0 || bus.btb_update_target !== 32'h80) begin failures++; $display("FAIL t1_btb got=%0h/%0h/%0h/%0h exp=1/1/0/80", bus.btb_update_en, bus.btb_update_index, bus.btb_update_tag, bus.btb_update_target); end
    checks++; if (bus.cnt_mispredicts !== 32'd1 || bus.cnt_branches !== 32'd1) begin failures++; $display("FAIL t1_counters got=%0h/%0h exp=1/1", bus.cnt_branches, bus.cnt_mispredicts); end
    step();
    checks++; if (bus.redirect_valid !== 1'b0 || bus.flush_if_id !== 1'b0 || bus.pred_update_en !== 1'b0) begin failures++; $display("FAIL t1_one_cycle got=%0h/%0h/%0h exp=0/0/0", bus.redirect_valid, bus.flush_if_id, bus.pred_update_en); end
  endtask

  task automatic test_correct_prediction;
    load_meta(1, 1, 32'h80);
    resolve(32'h40, 1, 0, 1, 32'h80);
    checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL t2_redirect got=%0h exp=0", bus.redirect_valid); end
    checks++; if (bus.pred_update_en !== 1'b1 || bus.btb_update_en !== 1'b0) begin failures++; $display("FAIL t2_updates got=%0h/%0h exp=1/0", bus.pred_update_en, bus.btb_update_en); end
    checks++; if (bus.cnt_branches !== 32'd2 || bus.cnt_mispredicts !== 32'd1) begin failures++; $display("FAIL t2_counters got=%0h/%0h exp=2/1", bus.cnt_branches, bus.cnt_mispredicts); end
    step();
  endtask

  task automatic test_alias_noncontrol;
    load_meta(1, 1, 32'h80);
    resolve(32'h44, 0, 0, 0, 32'h0);
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h48) begin failures++; $display("FAIL t3_redirect got=%0h/%0h exp=1/48", bus.redirect_valid, bus.redirect_pc); end
    checks++; if (bus.pred_update_en !== 1'b0 || bus.btb_update_en !== 1'b0) begin failures++; $display("FAIL t3_updates got=%0h/%0h exp=0/0", bus.pred_update_en, bus.btb_update_en); end
    checks++; if (bus.cnt_branches !== 32'd2 || bus.cnt_mispredicts !== 32'd2) begin failures++; $display("FAIL t3_counters got=%0h/%0h exp=2/2", bus.cnt_branches, bus.cnt_mispredicts); end
    step();
  endtask

  task automatic test_stall;
    load_meta(0, 0, 32'h0);
    bus.id_pc = 32'h100; bus.id_is_branch = 0; bus.id_is_jump = 1;
    bus.id_taken = 0; bus.id_target = 32'h200; bus.id_fire = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.redirect_valid !== 1'b0 || bus.pred_update_en !== 1'b0 || bus.btb_update_en !== 1'b0) begin failures++; $display("FAIL t4_stall_%0d got=%0h/%0h/%0h exp=0/0/0", i, bus.redirect_valid, bus.pred_update_en, bus.btb_update_en); end
    end
    bus.id_fire = 1;
    step();
    bus.id_fire = 0;
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h200) begin failures++; $display("FAIL t4_redirect got=%0h/%0h exp=1/200", bus.redirect_valid, bus.redirect_pc); end
    checks++; if (bus.btb_update_en !== 1'b1 || bus.btb_update_index !== 6'h04 || bus.btb_update_target !== 32'h200 || bus.pred_update_en !== 1'b0) begin failures++; $display("FAIL t4_updates got=%0h/%0h/%0h/%0h exp=1/4/200/0", bus.btb_update_en, bus.btb_update_index, bus.btb_update_target, bus.pred_update_en); end
    checks++; if (bus.cnt_branches !== 32'd3 || bus.cnt_mispredicts !== 32'd3) begin failures++; $display("FAIL t4_counters got=%0h/%0h exp=3/3", bus.cnt_branches, bus.cnt_mispredicts); end
    step();
  endtask

  task automatic test_flush_and_reset;
    load_meta(0, 0, 32'h0);
    resolve(32'h40, 1, 0, 1, 32'h80);
    checks++; if (bus.flush_if_id !== 1'b1) begin failures++; $display("FAIL t5_flush got=%0h exp=1", bus.flush_if_id); end
    bus.if_fire = 1; bus.if_pred_taken = 0; bus.if_btb_hit = 0; bus.if_btb_target = 0;
    step();
    bus.if_fire = 0;
    resolve(32'h40, 1, 0, 1, 32'h80);
    checks++; if (bus.pred_update_en !== 1'b0 || bus.btb_update_en !== 1'b0 || bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL t5_discarded got=%0h/%0h/%0h exp=0/0/0", bus.pred_update_en, bus.btb_update_en, bus.redirect_valid); end
    checks++; if (bus.cnt_branches !== 32'd4 || bus.cnt_mispredicts !== 32'd4) begin failures++; $display("FAIL t5_counters got=%0h/%0h exp=4/4", bus.cnt_branches, bus.cnt_mispredicts); end
    load_meta(0, 0, 32'h0);
    resolve(32'h40, 1, 0, 1, 32'h80);
    checks++; if (bus.redirect_valid !== 1'b1 || bus.cnt_mispredicts !== 32'd5) begin failures++; $display("FAIL t5_recover got=%0h/%0h exp=1/5", bus.redirect_valid, bus.cnt_mispredicts); end
    reset = 0;
    #1;
    checks++; if (bus.redirect_valid !== 1'b0 || bus.flush_if_id !== 1'b0) begin failures++; $display("FAIL t5_async_reset got=%0h/%0h exp=0/0", bus.redirect_valid, bus.flush_if_id); end
    checks++; if (bus.cnt_branches !== 32'd0 || bus.cnt_mispredicts !== 32'd0) begin failures++; $display("FAIL t5_reset_counters got=%0h/%0h exp=0/0", bus.cnt_branches, bus.cnt_mispredicts); end
    reset = 1;
    step();
  endtask

  task automatic test_wrap_and_retarget;
    load_meta(1, 1, 32'h100);
    resolve(32'hFFFF_FFFC, 0, 0, 0, 32'h0);
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0) begin failures++; $display("FAIL t6_wrap got=%0h/%0h exp=1/0", bus.redirect_valid, bus.redirect_pc); end
    checks++; if (bus.cnt_branches !== 32'd0 || bus.cnt_mispredicts !== 32'd1) begin failures++; $display("FAIL t6_counters got=%0h/%0h exp=0/1", bus.cnt_branches, bus.cnt_mispredicts); end
    step();
    load_meta(1, 1, 32'h300);
    resolve(32'h1234_5100, 0, 1, 0, 32'h200);
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h200) begin failures++; $display("FAIL t7_redirect got=%0h/%0h exp=1/200", bus.redirect_valid, bus.redirect_pc); end
    checks++; if (bus.btb_update_en !== 1'b1 || bus.btb_update_index !== 6'h04 || bus.btb_update_tag !== 20'h12345 || bus.btb_update_target !== 32'h200) begin failures++; $display("FAIL t7_btb got=%0h/%0h/%0h/%0h exp=1/4/12345/200", bus.btb_update_en, bus.btb_update_index, bus.btb_update_tag, bus.btb_update_target); end
    checks++; if (bus.cnt_branches !== 32'd1 || bus.cnt_mispredicts !== 32'd2) begin failures++; $display("FAIL t7_counters got=%0h/%0h exp=1/2", bus.cnt_branches, bus.cnt_mispredicts); end
    step();
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 8; i++) begin
      bus_s.if_fire = 1;
      step();
      bus_s.if_fire = 0;
      bus_s.id_pc = 32'h100; bus_s.id_is_jump = 1; bus_s.id_target = 32'h200; bus_s.id_fire = 1;
      step();
      bus_s.id_fire = 0;
      step();
      if (i == 6) begin
        checks++; if (bus_s.cnt_branches !== 3'd7 || bus_s.cnt_mispredicts !== 3'd7) begin failures++; $display("FAIL sat_reach got=%0h/%0h exp=7/7", bus_s.cnt_branches, bus_s.cnt_mispredicts); end
      end
    end
    checks++; if (bus_s.cnt_branches !== 3'd7 || bus_s.cnt_mispredicts !== 3'd7) begin failures++; $display("FAIL sat_hold got=%0h/%0h exp=7/7", bus_s.cnt_branches, bus_s.cnt_mispredicts); end
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    step();
    step();
    test_reset();
    test_mispredict_branch();
    test_correct_prediction();
    test_alias_noncontrol();
    test_stall();
    test_flush_and_reset();
    test_wrap_and_retarget();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
